axil_wr_sched: RTL and testbench

- Write-request scheduler that shares the low-priority write port of the AXI-lite write engine between NUM_REQ internal requesters (FSMs, DMA helpers, config sequencers).
- Arbitration is round-robin with optional fixed priority for requester 0 and a starvation guard.
- Issues one write at a time and holds it until the engine acks.
- A watchdog aborts hung transactions and reports them per requester.

---
 rtl/axil_wr_sched.sv | 158 +++++++++++++++
 tb/tb_axil_wr_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axil_wr_sched.sv
// axil_wr_sched
// Shares the low-priority write port of the AXI-lite write engine between
// NUM_REQ internal requesters. One write is in flight at a time. Winners are
// chosen round-robin, optionally with requester 0 favoured (bounded by a
// starvation guard). A watchdog aborts writes the engine never acknowledges.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset (sequencer port)
//   req_i          per-requester level request
//   addr_i/data_i  per-requester address/data, requester i at [i*32 +: 32]
//   ack_o / err_o  one-cycle completion / timeout pulse to the granted requester
//   wr_adress_o, wr_data_o, wr_req_o, wr_ack_i   write engine handshake
//   busy_o         high whenever the scheduler is not idle
//   grant_idx_o    index of the current or most recent grant
//   timeout_cnt_o  saturating count of aborted writes
module axil_wr_sched #(
  parameter int NUM_REQ    = 4,
  parameter int PRIO0      = 1,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*32-1:0]      addr_i,
  input  logic [NUM_REQ*32-1:0]      data_i,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic [NUM_REQ-1:0]         err_o,
  output logic [31:0]                wr_adress_o,
  output logic [31:0]                wr_data_o,
  output logic                       wr_req_o,
  input  logic                       wr_ack_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic [15:0]                timeout_cnt_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // The watchdog only needs to reach TIMEOUT-1.
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]       state_reg;
  logic [IDX_W-1:0] last_grant_reg;
  logic [15:0]      starve_reg;
  logic [WD_W-1:0]  wd_reg;

  logic [31:0] addr_arr [NUM_REQ];
  logic [31:0] data_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = addr_i[gi*32 +: 32];
      assign data_arr[gi] = data_i[gi*32 +: 32];
    end
  endgenerate

  // ---------------- arbitration ----------------
  logic             any_req;
  logic             others_waiting;
  logic             prio_win;
  logic             rr_found;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] win_idx;

  assign any_req        = |req_i;
  assign others_waiting = |req_i[NUM_REQ-1:1];
  assign prio_win       = (PRIO0 != 0) && req_i[0] &&
                          ((STARVE_LIM == 0) || (starve_reg < 16'(STARVE_LIM)));

  // Scan from the requester after the last grant, wrapping. When the guard
  // forces this path and only requester 0 is asking, the scan lands on 0.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_reg) + k) % NUM_REQ);
      if (!rr_found && req_i[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign win_idx = prio_win ? '0 : rr_idx;
  assign busy_o  = (state_reg != ST_IDLE);

  // ---------------- sequencing ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      starve_reg     <= '0;
      wd_reg         <= '0;
      ack_o          <= '0;
      err_o          <= '0;
      wr_adress_o    <= '0;
      wr_data_o      <= '0;
      wr_req_o       <= 1'b0;
      grant_idx_o    <= '0;
      timeout_cnt_o  <= '0;
    end else begin
      ack_o <= '0;
      err_o <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            wr_adress_o <= addr_arr[win_idx];
            wr_data_o   <= data_arr[win_idx];
            wr_req_o    <= 1'b1;
            grant_idx_o <= win_idx;
            wd_reg      <= '0;
            state_reg   <= ST_WAIT;
            // Count only priority grants that bypass someone else waiting.
            if (prio_win && others_waiting) begin
              if (STARVE_LIM != 0)
                starve_reg <= starve_reg + 16'd1;
            end else if ((win_idx != '0) || !others_waiting) begin
              starve_reg <= '0;
            end
          end
        end
        ST_WAIT: begin
          // Ack takes precedence over a coincident timeout.
          if (wr_ack_i) begin
            wr_req_o           <= 1'b0;
            ack_o[grant_idx_o] <= 1'b1;
            last_grant_reg     <= grant_idx_o;
            state_reg          <= ST_GAP;
          end else if ((TIMEOUT != 0) && (wd_reg == WD_W'(TIMEOUT - 1))) begin
            wr_req_o           <= 1'b0;
            err_o[grant_idx_o] <= 1'b1;
            last_grant_reg     <= grant_idx_o;
            state_reg          <= ST_GAP;
            if (timeout_cnt_o != 16'hFFFF)
              timeout_cnt_o <= timeout_cnt_o + 16'd1;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end
        ST_GAP: begin
          // One quiet cycle so the requester can drop req_i after ack_o.
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_wr_sched.sv
// Bench for axil_wr_sched. Instance a: PRIO0=1, STARVE_LIM=2, TIMEOUT=8.
// Instance b: PRIO0=0 (pure round-robin), TIMEOUT=8. Both share the data
// buses and the engine ack; the idle instance ignores the ack.
module tb_axil_wr_sched;

  logic         clk;
  logic         rst;
  logic [3:0]   req_a, req_b;
  logic [127:0] addr_bus, data_bus;
  logic         wr_ack;

  logic [3:0]  a_ack, a_err, b_ack, b_err;
  logic [31:0] a_addr, a_data, b_addr, b_data;
  logic        a_wr_req, b_wr_req, a_busy, b_busy;
  logic [1:0]  a_gidx, b_gidx;
  logic [15:0] a_tcnt, b_tcnt;

  axil_wr_sched #(.NUM_REQ(4), .PRIO0(1), .STARVE_LIM(2), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .req_i(req_a), .addr_i(addr_bus), .data_i(data_bus),
    .ack_o(a_ack), .err_o(a_err), .wr_adress_o(a_addr), .wr_data_o(a_data),
    .wr_req_o(a_wr_req), .wr_ack_i(wr_ack), .busy_o(a_busy),
    .grant_idx_o(a_gidx), .timeout_cnt_o(a_tcnt)
  );

  axil_wr_sched #(.NUM_REQ(4), .PRIO0(0), .STARVE_LIM(2), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .req_i(req_b), .addr_i(addr_bus), .data_i(data_bus),
    .ack_o(b_ack), .err_o(b_err), .wr_adress_o(b_addr), .wr_data_o(b_data),
    .wr_req_o(b_wr_req), .wr_ack_i(wr_ack), .busy_o(b_busy),
    .grant_idx_o(b_gidx), .timeout_cnt_o(b_tcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor mux: selects which instance the transaction checks look at.
  bit          use_b;
  logic [3:0]  m_ack, m_err;
  logic [31:0] m_addr, m_data;
  logic        m_wr_req, m_busy;
  logic [1:0]  m_gidx;
  logic [15:0] m_tcnt;

  always_comb begin
    m_ack    = use_b ? b_ack    : a_ack;
    m_err    = use_b ? b_err    : a_err;
    m_addr   = use_b ? b_addr   : a_addr;
    m_data   = use_b ? b_data   : a_data;
    m_wr_req = use_b ? b_wr_req : a_wr_req;
    m_busy   = use_b ? b_busy   : a_busy;
    m_gidx   = use_b ? b_gidx   : a_gidx;
    m_tcnt   = use_b ? b_tcnt   : a_tcnt;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] addr_val [4];
  logic [31:0] data_val [4];

  typedef struct {
    bit         use_b;
    logic [3:0] req_set;    // bits ORed into req before the grant
    logic [3:0] drop;       // bits cleared during the GAP cycle
    int         ack_delay;  // wr_req cycles before ack; -1 = never ack
    int         exp_grant;
    bit         exp_err;
    int         exp_tcnt;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts and ends at a negedge in an IDLE cycle.
  task automatic run_txn(input int id, input vec_t v);
    logic [3:0] exp_onehot;
    int cnt;
    exp_onehot = 4'(1) << v.exp_grant;
    use_b = v.use_b;
    if (v.use_b) req_b = req_b | v.req_set;
    else         req_a = req_a | v.req_set;
    @(negedge clk);
    check("latency",   64'(m_wr_req), 64'(1));
    check("grant_idx", 64'(m_gidx),   64'(v.exp_grant));
    check("wr_addr",   64'(m_addr),   64'(addr_val[v.exp_grant]));
    check("wr_data",   64'(m_data),   64'(data_val[v.exp_grant]));
    if (v.ack_delay < 0) begin
      cnt = 0;
      while (m_wr_req == 1'b1 && cnt < 20) begin
        cnt++;
        @(negedge clk);
      end
      check("req_cycles", 64'(cnt), 64'(8));
    end else begin
      repeat (v.ack_delay) @(negedge clk);
      check("hold_req",  64'(m_wr_req), 64'(1));
      check("hold_addr", 64'(m_addr),   64'(addr_val[v.exp_grant]));
      wr_ack = 1'b1;
      @(negedge clk);
      wr_ack = 1'b0;
    end
    // GAP cycle
    check("gap_req",  64'(m_wr_req), 64'(0));
    check("ack",      64'(m_ack),    64'(v.exp_err ? 4'b0000 : exp_onehot));
    check("err",      64'(m_err),    64'(v.exp_err ? exp_onehot : 4'b0000));
    check("busy_gap", 64'(m_busy),   64'(1));
    check("tcnt",     64'(m_tcnt),   64'(v.exp_tcnt));
    $display("[TB] txn %0d dut=%s grant=%0d ack=%b err=%b tcnt=%0d",
             id, v.use_b ? "b" : "a", m_gidx, m_ack, m_err, m_tcnt);
    if (v.use_b) req_b = req_b & ~v.drop;
    else         req_a = req_a & ~v.drop;
    @(negedge clk);
    check("busy_idle", 64'(m_busy),         64'(0));
    check("pulse_len", 64'(m_ack | m_err),  64'(0));
  endtask

  vec_t hv;

  initial begin
    addr_val = '{32'h4000_0000, 32'h4000_0010, 32'h4000_0020, 32'h4000_0030};
    data_val = '{32'h1111_0000, 32'hDEAD_BEEF, 32'h2222_0002, 32'h3333_0003};
    for (int i = 0; i < 4; i++) begin
      addr_bus[i*32 +: 32] = addr_val[i];
      data_bus[i*32 +: 32] = data_val[i];
    end

    //          use_b set      drop     dly gr err tcnt
    tbl[0]  = '{0, 4'b0010, 4'b0010,  3, 1, 0, 0};  // single request
    tbl[1]  = '{0, 4'b0101, 4'b0000,  1, 0, 0, 0};  // priority
    tbl[2]  = '{0, 4'b0000, 4'b0000,  2, 0, 0, 0};
    tbl[3]  = '{0, 4'b0000, 4'b0000,  0, 2, 0, 0};  // forced by guard
    tbl[4]  = '{0, 4'b0000, 4'b0000,  1, 0, 0, 0};
    tbl[5]  = '{0, 4'b0000, 4'b0000,  1, 0, 0, 0};
    tbl[6]  = '{0, 4'b0000, 4'b0101,  1, 2, 0, 0};
    tbl[7]  = '{0, 4'b0100, 4'b0100, -1, 2, 1, 1};  // timeout
    tbl[8]  = '{0, 4'b1000, 4'b1000,  2, 3, 0, 1};  // serviced after abort
    tbl[9]  = '{0, 4'b0010, 4'b0010,  7, 1, 0, 1};  // ack on 8th cycle wins
    tbl[10] = '{1, 4'b1111, 4'b0001,  1, 0, 0, 0};  // round-robin
    tbl[11] = '{1, 4'b0000, 4'b0010,  1, 1, 0, 0};
    tbl[12] = '{1, 4'b0000, 4'b0100,  2, 2, 0, 0};
    tbl[13] = '{1, 4'b0000, 4'b1000,  1, 3, 0, 0};
    tbl[14] = '{1, 4'b1111, 4'b0001,  1, 0, 0, 0};
    tbl[15] = '{1, 4'b0000, 4'b0010,  1, 1, 0, 0};
    tbl[16] = '{1, 4'b0000, 4'b0100,  1, 2, 0, 0};
    tbl[17] = '{1, 4'b0000, 4'b1000,  1, 3, 0, 0};
    tbl[18] = '{1, 4'b0010, 4'b0010,  1, 1, 0, 0};  // leaves last grant at 1

    use_b  = 1'b0;
    rst    = 1'b1;
    req_a  = '0;
    req_b  = '0;
    wr_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_req", 64'({a_wr_req, b_wr_req}), 64'(0));
    check("rst_busy",   64'({a_busy, b_busy}),     64'(0));
    check("rst_pulses", 64'({a_ack, a_err, b_ack, b_err}), 64'(0));
    check("rst_addr",   64'(a_addr | a_data),      64'(0));
    check("rst_misc",   64'({a_gidx, a_tcnt, b_gidx, b_tcnt}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) run_txn(i, tbl[i]);

    // Requester drops req and changes its address while in WAIT.
    use_b = 1'b0;
    req_a = 4'b0010;
    @(negedge clk);
    check("mid_req",   64'(a_wr_req), 64'(1));
    check("mid_grant", 64'(a_gidx),   64'(1));
    addr_bus[63:32] = 32'h1234_5678;
    data_bus[63:32] = 32'h0BAD_F00D;
    req_a = 4'b0000;
    repeat (2) @(negedge clk);
    check("mid_hold_req", 64'(a_wr_req), 64'(1));
    check("mid_addr",     64'(a_addr),   64'(32'h4000_0010));
    check("mid_data",     64'(a_data),   64'(32'hDEAD_BEEF));
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    check("mid_ack", 64'(a_ack), 64'(4'b0010));
    $display("[TB] txn mid dut=a grant=%0d ack=%b addr=0x%h", a_gidx, a_ack, a_addr);
    addr_bus[63:32] = addr_val[1];
    data_bus[63:32] = data_val[1];
    @(negedge clk);
    // Ack outside WAIT must be ignored.
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    check("stray_ack", 64'({a_ack, a_wr_req, a_busy}), 64'(0));
    @(negedge clk);

    // Reset while instance a waits on the engine (ack offered during reset).
    req_a = 4'b1000;
    @(negedge clk);
    check("rst_mid_grant", 64'({a_wr_req, a_gidx}), 64'({1'b1, 2'd3}));
    @(negedge clk);
    rst    = 1'b1;
    wr_ack = 1'b1;
    req_a  = 4'b0000;
    @(negedge clk);
    check("rst_mid_outs",  64'({a_wr_req, a_busy, a_ack, a_err}), 64'(0));
    check("rst_mid_regs",  64'({a_gidx, a_tcnt}), 64'(0));
    check("rst_mid_addr",  64'(a_addr | a_data), 64'(0));
    rst    = 1'b0;
    wr_ack = 1'b0;
    @(negedge clk);
    check("rst_no_pulse", 64'({a_ack, a_err, a_busy}), 64'(0));
    $display("[TB] txn rst dut=a wr_req=%b busy=%b tcnt=%0d", a_wr_req, a_busy, a_tcnt);

    // First round-robin grant after reset goes to requester 0.
    hv = '{1, 4'b1111, 4'b1111, 1, 0, 0, 0};
    run_txn(100, hv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
